ex_operand_stage: RTL and testbench

ID/EX pipeline stage feeding the ALU in the pipelined core. It registers decoded operands and controls, resolves data hazards by forwarding from the MEM and WB stages, and raises a one-cycle load-use stall. It drives the ALU's `opc`, `a` and `b` inputs directly, and passes the store data and control bits on to the EX/MEM register.

---
 rtl/ex_operand_stage.sv | 154 +++++++++++++++
 tb/tb_ex_operand_stage.sv | 356 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ex_operand_stage.sv
// ID/EX pipeline register feeding the ALU: captures decoded operands, forwards
// results from MEM/WB, and inserts a one-cycle bubble on a load-use hazard.
module ex_operand_stage #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         id_valid,
    input  logic [2:0]   id_alu_opc,
    input  logic         id_alu_src,
    input  logic [4:0]   id_rs1,
    input  logic [4:0]   id_rs2,
    input  logic [4:0]   id_rd,
    input  logic [N-1:0] id_rs1_data,
    input  logic [N-1:0] id_rs2_data,
    input  logic [N-1:0] id_imm,
    input  logic         id_reg_write,
    input  logic         id_mem_read,
    input  logic         id_mem_write,
    input  logic         flush,
    input  logic         mem_reg_write,
    input  logic [4:0]   mem_rd,
    input  logic [N-1:0] mem_result,
    input  logic         wb_reg_write,
    input  logic [4:0]   wb_rd,
    input  logic [N-1:0] wb_result,
    output logic [2:0]   alu_opc,
    output logic [N-1:0] alu_a,
    output logic [N-1:0] alu_b,
    output logic [N-1:0] ex_store_data,
    output logic [4:0]   ex_rd,
    output logic         ex_valid,
    output logic         ex_reg_write,
    output logic         ex_mem_read,
    output logic         ex_mem_write,
    output logic         stall,
    output logic [1:0]   fwd_a,
    output logic [1:0]   fwd_b
);

    logic         valid_q;
    logic [2:0]   opc_q;
    logic         alu_src_q;
    logic [4:0]   rs1_q;
    logic [4:0]   rs2_q;
    logic [4:0]   rd_q;
    logic [N-1:0] rs1_val_q;
    logic [N-1:0] rs2_val_q;
    logic [N-1:0] imm_q;
    logic         reg_write_q;
    logic         mem_read_q;
    logic         mem_write_q;

    logic [N-1:0] cap_rs1_val;
    logic [N-1:0] cap_rs2_val;
    logic         load_bubble;
    logic [N-1:0] fwd_rs1_val;
    logic [N-1:0] fwd_rs2_val;

    assign stall = valid_q & mem_read_q & (rd_q != 5'd0) & id_valid &
                   ((id_rs1 == rd_q) | (id_rs2 == rd_q));

    assign load_bubble = flush | stall;

    // The register file writes and reads in the same cycle, so a WB write to a
    // source register must be picked up here or the old value would be latched.
    always_comb begin
        cap_rs1_val = id_rs1_data;
        cap_rs2_val = id_rs2_data;
        if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs1))
            cap_rs1_val = wb_result;
        if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == id_rs2))
            cap_rs2_val = wb_result;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q     <= 1'b0;
            opc_q       <= 3'b000;
            alu_src_q   <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else if (load_bubble) begin
            valid_q     <= 1'b0;
            opc_q       <= 3'b000;
            alu_src_q   <= 1'b0;
            rs1_q       <= 5'd0;
            rs2_q       <= 5'd0;
            rd_q        <= 5'd0;
            rs1_val_q   <= '0;
            rs2_val_q   <= '0;
            imm_q       <= '0;
            reg_write_q <= 1'b0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
        end else begin
            valid_q     <= id_valid;
            opc_q       <= id_alu_opc;
            alu_src_q   <= id_alu_src;
            rs1_q       <= id_rs1;
            rs2_q       <= id_rs2;
            rd_q        <= id_rd;
            rs1_val_q   <= cap_rs1_val;
            rs2_val_q   <= cap_rs2_val;
            imm_q       <= id_imm;
            reg_write_q <= id_reg_write;
            mem_read_q  <= id_mem_read;
            mem_write_q <= id_mem_write;
        end
    end

    // MEM holds the younger result, so it wins over WB; x0 is never forwarded.
    always_comb begin
        fwd_a       = 2'b00;
        fwd_rs1_val = rs1_val_q;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs1_q)) begin
            fwd_a       = 2'b10;
            fwd_rs1_val = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs1_q)) begin
            fwd_a       = 2'b01;
            fwd_rs1_val = wb_result;
        end
    end

    always_comb begin
        fwd_b       = 2'b00;
        fwd_rs2_val = rs2_val_q;
        if (mem_reg_write && (mem_rd != 5'd0) && (mem_rd == rs2_q)) begin
            fwd_b       = 2'b10;
            fwd_rs2_val = mem_result;
        end else if (wb_reg_write && (wb_rd != 5'd0) && (wb_rd == rs2_q)) begin
            fwd_b       = 2'b01;
            fwd_rs2_val = wb_result;
        end
    end

    assign alu_opc       = opc_q;
    assign alu_a         = fwd_rs1_val;
    assign alu_b         = alu_src_q ? imm_q : fwd_rs2_val;
    assign ex_store_data = fwd_rs2_val;
    assign ex_rd         = rd_q;
    assign ex_valid      = valid_q;
    assign ex_reg_write  = reg_write_q;
    assign ex_mem_read   = mem_read_q;
    assign ex_mem_write  = mem_write_q;

endmodule

// File: tb/tb_ex_operand_stage.sv
// Self-checking bench for ex_operand_stage: directed scenarios plus a random run
// compared against an instruction-level model of the EX stage.
module tb_ex_operand_stage;

    localparam int N = 32;

    logic         clk;
    logic         rst_n;
    logic         id_valid;
    logic [2:0]   id_alu_opc;
    logic         id_alu_src;
    logic [4:0]   id_rs1, id_rs2, id_rd;
    logic [N-1:0] id_rs1_data, id_rs2_data, id_imm;
    logic         id_reg_write, id_mem_read, id_mem_write;
    logic         flush;
    logic         mem_reg_write;
    logic [4:0]   mem_rd;
    logic [N-1:0] mem_result;
    logic         wb_reg_write;
    logic [4:0]   wb_rd;
    logic [N-1:0] wb_result;
    logic [2:0]   alu_opc;
    logic [N-1:0] alu_a, alu_b, ex_store_data;
    logic [4:0]   ex_rd;
    logic         ex_valid, ex_reg_write, ex_mem_read, ex_mem_write;
    logic         stall;
    logic [1:0]   fwd_a, fwd_b;

    int passed = 0;
    int total  = 0;

    ex_operand_stage #(.N(N)) dut (
        .clk(clk), .rst_n(rst_n),
        .id_valid(id_valid), .id_alu_opc(id_alu_opc), .id_alu_src(id_alu_src),
        .id_rs1(id_rs1), .id_rs2(id_rs2), .id_rd(id_rd),
        .id_rs1_data(id_rs1_data), .id_rs2_data(id_rs2_data), .id_imm(id_imm),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .id_mem_write(id_mem_write),
        .flush(flush),
        .mem_reg_write(mem_reg_write), .mem_rd(mem_rd), .mem_result(mem_result),
        .wb_reg_write(wb_reg_write), .wb_rd(wb_rd), .wb_result(wb_result),
        .alu_opc(alu_opc), .alu_a(alu_a), .alu_b(alu_b), .ex_store_data(ex_store_data),
        .ex_rd(ex_rd), .ex_valid(ex_valid), .ex_reg_write(ex_reg_write),
        .ex_mem_read(ex_mem_read), .ex_mem_write(ex_mem_write),
        .stall(stall), .fwd_a(fwd_a), .fwd_b(fwd_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the instruction currently sitting in EX.
    typedef struct {
        logic         valid;
        logic [2:0]   opc;
        logic         src;
        logic [4:0]   rs1, rs2, rd;
        logic [N-1:0] v1, v2, imm;
        logic         rw, mr, mw;
    } instr_t;

    instr_t m;

    function automatic instr_t bubble();
        instr_t b;
        b.valid = 0; b.opc = 0; b.src = 0; b.rs1 = 0; b.rs2 = 0; b.rd = 0;
        b.v1 = 0; b.v2 = 0; b.imm = 0; b.rw = 0; b.mr = 0; b.mw = 0;
        return b;
    endfunction

    function automatic logic exp_stall();
        if (!(m.valid && m.mr && m.rd != 0 && id_valid)) return 1'b0;
        return (id_rs1 == m.rd) || (id_rs2 == m.rd);
    endfunction

    // Value a register-file read returns when WB writes that register this cycle.
    function automatic logic [N-1:0] rf_read(input logic [4:0] r, input logic [N-1:0] d);
        if (wb_reg_write && wb_rd == r && r != 0) return wb_result;
        return d;
    endfunction

    function automatic logic [1:0] exp_src(input logic [4:0] r);
        if (r == 0) return 2'b00;
        if (mem_reg_write && mem_rd == r) return 2'b10;
        if (wb_reg_write && wb_rd == r) return 2'b01;
        return 2'b00;
    endfunction

    function automatic logic [N-1:0] exp_val(input logic [4:0] r, input logic [N-1:0] v);
        logic [1:0] s;
        s = exp_src(r);
        if (s == 2'b10) return mem_result;
        if (s == 2'b01) return wb_result;
        return v;
    endfunction

    function automatic instr_t m_next();
        instr_t n;
        if (!rst_n || flush || exp_stall()) return bubble();
        n.valid = id_valid; n.opc = id_alu_opc; n.src = id_alu_src;
        n.rs1 = id_rs1; n.rs2 = id_rs2; n.rd = id_rd;
        n.v1 = rf_read(id_rs1, id_rs1_data);
        n.v2 = rf_read(id_rs2, id_rs2_data);
        n.imm = id_imm; n.rw = id_reg_write; n.mr = id_mem_read; n.mw = id_mem_write;
        return n;
    endfunction

    task automatic tick();
        instr_t n;
        n = m_next();
        @(posedge clk);
        m = n;
        #1;
    endtask

    task automatic clear_inputs();
        id_valid = 0; id_alu_opc = 0; id_alu_src = 0;
        id_rs1 = 0; id_rs2 = 0; id_rd = 0;
        id_rs1_data = 0; id_rs2_data = 0; id_imm = 0;
        id_reg_write = 0; id_mem_read = 0; id_mem_write = 0;
        flush = 0;
        mem_reg_write = 0; mem_rd = 0; mem_result = 0;
        wb_reg_write = 0; wb_rd = 0; wb_result = 0;
    endtask

    task automatic present(input logic [2:0] opc, input logic [4:0] rs1, input logic [4:0] rs2,
                           input logic [4:0] rd, input logic [N-1:0] d1, input logic [N-1:0] d2,
                           input logic rw, input logic mr, input logic mw);
        id_valid = 1; id_alu_opc = opc; id_alu_src = 0;
        id_rs1 = rs1; id_rs2 = rs2; id_rd = rd;
        id_rs1_data = d1; id_rs2_data = d2; id_imm = 0;
        id_reg_write = rw; id_mem_read = mr; id_mem_write = mw;
    endtask

    task automatic test_reset();
        clear_inputs();
        rst_n = 0;
        m = bubble();
        present(3'b101, 5'd1, 5'd2, 5'd3, 32'hDEAD, 32'hBEEF, 1, 1, 1);
        repeat (2) tick();
        total++; if (alu_a !== 0 || alu_b !== 0 || ex_store_data !== 0) begin
            $display("[TB] FAIL reset_data: a=%h b=%h sd=%h required 0", alu_a, alu_b, ex_store_data);
        end else passed++;
        total++; if ({alu_opc, ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 12'd0) begin
            $display("[TB] FAIL reset_ctrl: opc=%b rd=%0d v=%b rw=%b mr=%b mw=%b required 0",
                     alu_opc, ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write);
        end else passed++;
        total++; if ({stall, fwd_a, fwd_b} !== 5'd0) begin
            $display("[TB] FAIL reset_hazard: stall=%b fwd_a=%b fwd_b=%b required 0", stall, fwd_a, fwd_b);
        end else passed++;
        rst_n = 1;
        present(3'b000, 5'd1, 5'd2, 5'd3, 32'd5, 32'd7, 1, 0, 0);
        tick();
        total++; if (alu_a !== 32'd5 || alu_b !== 32'd7) begin
            $display("[TB] FAIL first_capture_data: a=%0d b=%0d required 5 7", alu_a, alu_b);
        end else passed++;
        total++; if (alu_opc !== 3'b000 || ex_reg_write !== 1'b1 || ex_valid !== 1'b1 || ex_rd !== 5'd3) begin
            $display("[TB] FAIL first_capture_ctrl: opc=%b rw=%b v=%b rd=%0d required 000 1 1 3",
                     alu_opc, ex_reg_write, ex_valid, ex_rd);
        end else passed++;
    endtask

    task automatic test_mem_wb_priority();
        clear_inputs();
        present(3'b001, 5'd4, 5'd8, 5'd5, 32'h99, 32'h42, 1, 0, 0);
        tick();
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 4; mem_result = 32'h11;
        wb_reg_write = 1; wb_rd = 4; wb_result = 32'h22;
        #1;
        total++; if (alu_a !== 32'h11 || fwd_a !== 2'b10) begin
            $display("[TB] FAIL mem_priority: a=%h fwd_a=%b required 11 10", alu_a, fwd_a);
        end else passed++;
        mem_reg_write = 0;
        #1;
        total++; if (alu_a !== 32'h22 || fwd_a !== 2'b01) begin
            $display("[TB] FAIL wb_forward: a=%h fwd_a=%b required 22 01", alu_a, fwd_a);
        end else passed++;
        wb_reg_write = 0;
        #1;
        total++; if (alu_a !== 32'h99 || fwd_a !== 2'b00 || alu_b !== 32'h42) begin
            $display("[TB] FAIL no_forward: a=%h b=%h fwd_a=%b required 99 42 00", alu_a, alu_b, fwd_a);
        end else passed++;
        tick();
    endtask

    task automatic test_x0_guard();
        clear_inputs();
        present(3'b010, 5'd0, 5'd0, 5'd1, 32'h55, 32'h66, 1, 0, 0);
        tick();
        id_valid = 0;
        mem_reg_write = 1; mem_rd = 0; mem_result = 32'hFF;
        wb_reg_write = 1; wb_rd = 0; wb_result = 32'hEE;
        #1;
        total++; if (alu_a !== 32'h55 || fwd_a !== 2'b00) begin
            $display("[TB] FAIL x0_guard_a: a=%h fwd_a=%b required 55 00", alu_a, fwd_a);
        end else passed++;
        total++; if (ex_store_data !== 32'h66 || fwd_b !== 2'b00) begin
            $display("[TB] FAIL x0_guard_b: sd=%h fwd_b=%b required 66 00", ex_store_data, fwd_b);
        end else passed++;
        tick();
    endtask

    task automatic test_load_use();
        clear_inputs();
        present(3'b000, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 1, 1, 0);
        tick();
        present(3'b011, 5'd2, 5'd6, 5'd7, 32'h10, 32'h20, 1, 0, 0);
        #1;
        total++; if (stall !== 1'b1) begin
            $display("[TB] FAIL load_use_stall: stall=%b required 1", stall);
        end else passed++;
        tick();
        total++; if (ex_valid !== 1'b0 || stall !== 1'b0 || ex_mem_read !== 1'b0) begin
            $display("[TB] FAIL load_use_bubble: v=%b stall=%b mr=%b required 0 0 0", ex_valid, stall, ex_mem_read);
        end else passed++;
        tick();
        total++; if (ex_valid !== 1'b1 || ex_rd !== 5'd7 || alu_opc !== 3'b011 || alu_a !== 32'h10 || alu_b !== 32'h20) begin
            $display("[TB] FAIL load_use_replay: v=%b rd=%0d opc=%b a=%h b=%h required 1 7 011 10 20",
                     ex_valid, ex_rd, alu_opc, alu_a, alu_b);
        end else passed++;
    endtask

    task automatic test_flush();
        clear_inputs();
        present(3'b000, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 1, 0, 1);
        flush = 1;
        tick();
        total++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'd0 || ex_rd !== 0) begin
            $display("[TB] FAIL flush_bubble: v=%b rw=%b mr=%b mw=%b rd=%0d required 0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, ex_rd);
        end else passed++;
        flush = 0;
        present(3'b000, 5'd1, 5'd0, 5'd6, 32'h100, 32'h0, 1, 1, 0);
        tick();
        present(3'b100, 5'd6, 5'd3, 5'd8, 32'h3, 32'h4, 1, 0, 0);
        flush = 1;
        #1;
        total++; if (stall !== 1'b1) begin
            $display("[TB] FAIL flush_stall_overlap_stall: stall=%b required 1", stall);
        end else passed++;
        tick();
        total++; if ({ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !== 4'd0 || alu_opc !== 3'b000) begin
            $display("[TB] FAIL flush_stall_bubble: v=%b rw=%b mr=%b mw=%b opc=%b required 0",
                     ex_valid, ex_reg_write, ex_mem_read, ex_mem_write, alu_opc);
        end else passed++;
        flush = 0;
    endtask

    task automatic test_bypass_imm();
        clear_inputs();
        present(3'b000, 5'd9, 5'd10, 5'd11, 32'h0, 32'h77, 1, 0, 1);
        id_alu_src = 1; id_imm = 32'hFFFF_FFF0;
        wb_reg_write = 1; wb_rd = 9; wb_result = 32'h1234;
        tick();
        clear_inputs();
        #1;
        total++; if (alu_a !== 32'h1234) begin
            $display("[TB] FAIL capture_bypass: a=%h required 1234", alu_a);
        end else passed++;
        total++; if (alu_b !== 32'hFFFF_FFF0 || ex_store_data !== 32'h77) begin
            $display("[TB] FAIL imm_select: b=%h sd=%h required fffffff0 77", alu_b, ex_store_data);
        end else passed++;
        mem_reg_write = 1; mem_rd = 10; mem_result = 32'hABCD;
        #1;
        total++; if (alu_b !== 32'hFFFF_FFF0 || ex_store_data !== 32'hABCD || fwd_b !== 2'b10) begin
            $display("[TB] FAIL imm_store_fwd: b=%h sd=%h fwd_b=%b required fffffff0 abcd 10",
                     alu_b, ex_store_data, fwd_b);
        end else passed++;
        mem_reg_write = 0;
        tick();
    endtask

    task automatic test_reset_mid_stall();
        clear_inputs();
        present(3'b000, 5'd1, 5'd0, 5'd5, 32'h1, 32'h0, 1, 1, 0);
        tick();
        present(3'b000, 5'd5, 5'd0, 5'd2, 32'h1, 32'h0, 1, 0, 0);
        #2;
        rst_n = 0;
        m = bubble();
        #1;
        total++; if (stall !== 1'b0 || ex_valid !== 1'b0 || ex_mem_read !== 1'b0 || ex_rd !== 5'd0) begin
            $display("[TB] FAIL reset_mid_stall: stall=%b v=%b mr=%b rd=%0d required 0",
                     stall, ex_valid, ex_mem_read, ex_rd);
        end else passed++;
        tick();
        rst_n = 1;
        clear_inputs();
        tick();
    endtask

    task automatic test_random();
        logic hold;
        logic [N-1:0] ea, eb, esd;
        hold = 0;
        for (int i = 0; i < 400; i++) begin
            if (!hold) begin
                id_valid = ($urandom_range(0, 9) != 0);
                id_alu_opc = 3'($urandom_range(0, 5));
                id_alu_src = 1'($urandom);
                id_rs1 = 5'($urandom_range(0, 7));
                id_rs2 = 5'($urandom_range(0, 7));
                id_rd = 5'($urandom_range(0, 7));
                id_rs1_data = $urandom; id_rs2_data = $urandom; id_imm = $urandom;
                id_reg_write = 1'($urandom);
                id_mem_read = ($urandom_range(0, 2) == 0);
                id_mem_write = 1'($urandom);
            end
            flush = ($urandom_range(0, 9) == 0);
            mem_reg_write = 1'($urandom); mem_rd = 5'($urandom_range(0, 7)); mem_result = $urandom;
            wb_reg_write = 1'($urandom); wb_rd = 5'($urandom_range(0, 7)); wb_result = $urandom;
            #1;
            ea = exp_val(m.rs1, m.v1);
            esd = exp_val(m.rs2, m.v2);
            eb = m.src ? m.imm : esd;
            total++; if (alu_a !== ea) begin
                $display("[TB] FAIL rnd_alu_a[%0d]: got %h required %h", i, alu_a, ea);
            end else passed++;
            total++; if (alu_b !== eb) begin
                $display("[TB] FAIL rnd_alu_b[%0d]: got %h required %h", i, alu_b, eb);
            end else passed++;
            total++; if (ex_store_data !== esd) begin
                $display("[TB] FAIL rnd_store[%0d]: got %h required %h", i, ex_store_data, esd);
            end else passed++;
            total++; if (fwd_a !== exp_src(m.rs1) || fwd_b !== exp_src(m.rs2)) begin
                $display("[TB] FAIL rnd_fwd[%0d]: got %b %b required %b %b", i, fwd_a, fwd_b,
                         exp_src(m.rs1), exp_src(m.rs2));
            end else passed++;
            total++; if (stall !== exp_stall()) begin
                $display("[TB] FAIL rnd_stall[%0d]: got %b required %b", i, stall, exp_stall());
            end else passed++;
            total++; if ({alu_opc, ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write} !==
                         {m.opc, m.rd, m.valid, m.rw, m.mr, m.mw}) begin
                $display("[TB] FAIL rnd_ctrl[%0d]: got %b required %b", i,
                         {alu_opc, ex_rd, ex_valid, ex_reg_write, ex_mem_read, ex_mem_write},
                         {m.opc, m.rd, m.valid, m.rw, m.mr, m.mw});
            end else passed++;
            hold = exp_stall() && !flush;
            tick();
        end
    endtask

    initial begin
        $display("[TB] ex_operand_stage bench start");
        test_reset();
        test_mem_wb_priority();
        test_x0_guard();
        test_load_use();
        test_flush();
        test_bypass_imm();
        test_reset_mid_stall();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
